// File: rtl/tm_snn_pkg.sv
// Shared constants and readout state encoding for the spike-rate decoder.
// Pure definitions: no latency, no flow control.
package tm_snn_pkg;

    localparam int NUM_CHAN = 8;
    localparam int CHAN_W   = 3;
    localparam int RATE_SAT = 255;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rd_state_t;

endpackage

// File: rtl/tm_spike_counter.sv
// One channel spike counter with increment and synchronous restart; count_next is the value including this edge's spike.
// Latency: count_next is combinational from the held count; backpressure: none.
module tm_spike_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             restart,
    output logic [CNT_W-1:0] count_next
);

    logic [CNT_W-1:0] count;

    assign count_next = count + CNT_W'(inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/tm_spike_decoder.sv
// Windowed 8-channel spike-rate decoder; rate_valid rises 1 cycle after the window-close edge. Build option: TM_DECODE_SAT_EN.
// Backpressure: rate_ready stalls the readout; a window closing mid-readout is dropped and sets overrun.
module tm_spike_decoder
    import tm_snn_pkg::*;
#(
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CHAN-1:0] spike_in,
    input  logic                spike_valid,
    output logic [7:0]          rate_out,
    output logic [CHAN_W-1:0]   rate_chan,
    output logic                rate_valid,
    input  logic                rate_ready,
    output logic                window_done,
    output logic                overrun
);

    localparam int CNT_W = WINDOW_LOG2 + 1;

    logic [WINDOW_LOG2-1:0] samp_cnt;
    logic                   win_close;
    logic [CNT_W-1:0]       cnt_next [NUM_CHAN];
    logic [CNT_W-1:0]       snap     [NUM_CHAN];

    rd_state_t         state, state_nxt;
    logic [CHAN_W-1:0] chan, chan_nxt;
    logic              xfer, last_xfer, snap_load;

    // The sample counter wraps to zero on its own exactly at window close.
    assign win_close = spike_valid && (samp_cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
        end else if (spike_valid) begin
            samp_cnt <= samp_cnt + WINDOW_LOG2'(1);
        end
    end

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        tm_spike_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc        (spike_valid & spike_in[i]),
            .restart    (win_close),
            .count_next (cnt_next[i])
        );
    end

    always_comb begin
        state_nxt = state;
        chan_nxt  = chan;
        xfer      = (state == R_SEND) && rate_ready;
        last_xfer = xfer && (chan == CHAN_W'(NUM_CHAN - 1));
        // A close on the final transfer edge chains straight into the next readout.
        snap_load = win_close && ((state == R_IDLE) || last_xfer);
        if (snap_load) begin
            state_nxt = R_SEND;
            chan_nxt  = '0;
        end else if (xfer) begin
            chan_nxt = chan + CHAN_W'(1);
            if (last_xfer) begin
                state_nxt = R_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= R_IDLE;
            chan  <= '0;
        end else begin
            state <= state_nxt;
            chan  <= chan_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                snap[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                snap[i] <= cnt_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            window_done <= win_close;
            if (win_close && !snap_load) begin
                overrun <= 1'b1;
            end
        end
    end

    assign rate_valid = (state == R_SEND);
    assign rate_chan  = chan;

`ifdef TM_DECODE_SAT_EN
    logic [8:0] rate_cnt;
    assign rate_cnt = 9'(snap[chan]);
    assign rate_out = (rate_cnt > 9'(RATE_SAT)) ? 8'(RATE_SAT) : rate_cnt[7:0];
`else
    assign rate_out = 8'(snap[chan]);
`endif

endmodule

// File: doc/tm_spike_decoder.md
TM_SPIKE_DECODER -- requirements
Module: tm_spike_decoder

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 4, meaning the window length is 2^WINDOW_LOG2 accepted samples; legal range 1..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-004 SHALL have port spike_in, input, 8 bits: spike vector, one bit per neuron channel 0..7.
REQ-005 SHALL have port spike_valid, input, 1 bit: spike_in is sampled on edges where this is high.
REQ-006 SHALL have port rate_out, output, 8 bits: spike count of channel rate_chan for the last completed window.
REQ-007 SHALL have port rate_chan, output, 3 bits: channel index of rate_out.
REQ-008 SHALL have port rate_valid, output, 1 bit: rate_out and rate_chan hold a readout word.
REQ-009 SHALL have port rate_ready, input, 1 bit: the consumer accepts the word.
REQ-010 SHALL have port window_done, output, 1 bit: one-cycle pulse after each window closes.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when a window snapshot is dropped.

Function
REQ-012 SHALL keep eight per-channel counters, each WINDOW_LOG2+1 bits wide, plus a sample counter of WINDOW_LOG2 bits.
REQ-013 SHALL, on each edge with spike_valid=1, increment every channel counter whose spike_in bit is 1 and increment the sample counter.
REQ-014 SHALL treat the edge accepting sample number 2^WINDOW_LOG2 as window close: counts including that sample go to the snapshot, and all counters restart at 0 on the same edge with no sample lost.
REQ-015 SHALL ignore spike_in and hold all counters when spike_valid=0.
REQ-016 SHALL pulse window_done high for exactly the cycle following every window close, including dropped ones.
REQ-017 SHALL run readout FSM R_IDLE/R_SEND: R_IDLE -> R_SEND on snapshot load (rate_valid=1, rate_chan=0); in R_SEND each edge with rate_valid & rate_ready advances rate_chan; the transfer of channel 7 returns to R_IDLE.
REQ-018 SHALL hold rate_out and rate_chan stable while rate_valid=1 and rate_ready=0.
REQ-019 SHALL load the snapshot on a window close in R_IDLE, or coincident with the channel-7 transfer edge (restart at channel 0, no overrun, no idle cycle).
REQ-020 SHALL, on a window close in R_SEND other than REQ-019, discard the new snapshot, keep the current readout intact, and set overrun.
REQ-021 SHALL keep accumulating during readout (snapshot double-buffers counters).
REQ-022 SHALL have latency 1 cycle: rate_valid is high in the cycle after the window-close edge.

Reset
REQ-023 SHALL, while rst=1, clear all counters and the snapshot, force R_IDLE, and drive rate_out=0, rate_chan=0, rate_valid=0, window_done=0, overrun=0.
REQ-024 SHALL abandon any partial window or readout on reset mid-operation; the first window after release starts at sample 0.

Configuration
REQ-025 SHALL honour macro TM_DECODE_SAT_EN: when defined, rate_out = min(count, 255); when undefined, rate_out = count[7:0] (a count of 256 at WINDOW_LOG2=8 reads 0).

Structure
REQ-026 SHALL place the channel count (8), channel-index width (3), readout FSM state encoding, and the rate saturation limit (255) in shared package tm_snn_pkg.
REQ-027 SHALL instantiate sub-module tm_spike_counter once per channel, which holds one counter with increment and synchronous restart.

Verification
REQ-028 SHALL cover: WINDOW_LOG2=4, spike_in=8'h05 for 16 valid samples, rate_ready=1 -> words ch0=16, ch1=0, ch2=16, ch3..7=0 on 8 consecutive cycles.
REQ-029 SHALL cover: valid gaps; spike_in=8'h80 on alternate samples across 16 valid samples spread over 40 cycles -> ch7=8, window_done pulses once.
REQ-030 SHALL cover: rate_ready=0 for 20 cycles after a close -> rate_chan stays 0 and rate_out stable; after release, ch0..7 are delivered in order.
REQ-031 SHALL cover: rate_ready=0 through a second window close -> overrun=1, first snapshot delivered unchanged; channel-7 transfer coincident with a close -> next ch0 follows immediately, overrun stays 0.
REQ-032 SHALL cover: WINDOW_LOG2=8, spike_in=8'hFF for 256 samples -> rate_out=255 with TM_DECODE_SAT_EN, 0 without.
REQ-033 SHALL cover: rst asserted mid-readout at rate_chan=3 -> all outputs 0 immediately; next window reports counts from post-reset samples only.
